// File: rtl/trace_pkg.sv
// Shared constants for the register-write trace buffer.
// Field widths, default watch mask and full-FIFO policy codes.
package trace_pkg;

  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_REG_AW = 5;
  localparam int TRACE_CNT_W  = 16;
  localparam int TRACE_DEPTH  = 16;

  // $t0-$t9 and $s0-$s7
  localparam logic [31:0] TRACE_MASK_ST = 32'h03FF_FF00;

  localparam bit TRACE_DROP      = 1'b0;
  localparam bit TRACE_OVERWRITE = 1'b1;

endpackage

// File: rtl/trace_fifo.sv
// Generic DEPTH x W FIFO with clear, drop-or-overwrite when full.
// Ports: push/wdata in, pop in, rdata/level/full/empty/drop out.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int W         = 8,
  parameter bit OVERWRITE = TRACE_DROP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;

  logic do_pop;
  logic blocked;
  logic ovw;
  logic wr_en;
  logic rd_adv;

  assign empty = (lvl_q == '0);
  assign full  = (lvl_q == LW'(DEPTH));
  assign level = lvl_q;
  assign rdata = mem_q[rd_q];

  // A pop in the same cycle frees the slot, so only an
  // unpopped push into a full FIFO is blocked.
  assign do_pop  = pop & ~empty;
  assign blocked = push & full & ~do_pop;
  assign ovw     = blocked & OVERWRITE;
  assign wr_en   = push & (~blocked | OVERWRITE);
  assign rd_adv  = do_pop | ovw;
  assign drop    = blocked & ~clear;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + 1'b1;
      end
      if (rd_adv) rd_d = rd_q + 1'b1;
      if (wr_en & ~rd_adv) lvl_d = lvl_q + 1'b1;
      else if (~wr_en & rd_adv) lvl_d = lvl_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/reg_write_tracer.sv
// Register-file write snooper: timestamps watched writes into a FIFO.
// Ports: snoop (pc/reg_write/write_reg/write_data), out_* stream, status.
module reg_write_tracer
  import trace_pkg::*;
#(
  parameter int DATA_W    = TRACE_DATA_W,
  parameter int REG_AW    = TRACE_REG_AW,
  parameter int DEPTH     = TRACE_DEPTH,
  parameter int CNT_W     = TRACE_CNT_W,
  parameter logic [(2**REG_AW)-1:0] WATCH_MASK = TRACE_MASK_ST,
  parameter bit OVERWRITE = TRACE_DROP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   capture_en,
  input  logic                   clear,
  input  logic [DATA_W-1:0]      pc,
  input  logic                   reg_write,
  input  logic [REG_AW-1:0]      write_reg,
  input  logic [DATA_W-1:0]      write_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       out_cycle,
  output logic [DATA_W-1:0]      out_pc,
  output logic [REG_AW-1:0]      out_reg,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic [7:0]             dropped
);

  localparam int RW = CNT_W + DATA_W + REG_AW + DATA_W;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       drop_q, drop_d;
  logic             qual;
  logic             fifo_drop;
  logic [RW-1:0]    rec_in;
  logic [RW-1:0]    rec_out;

  assign qual = capture_en & reg_write
              & (write_reg != '0)
              & WATCH_MASK[write_reg];

  assign rec_in = {cnt_q, pc, write_reg, write_data};
  assign {out_cycle, out_pc, out_reg, out_data} = rec_out;

  assign out_valid = ~empty;
  assign dropped   = drop_q;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    drop_d = drop_q;
    if (clear) drop_d = '0;
    else if (fifo_drop && drop_q != 8'hFF) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  trace_fifo #(
    .DEPTH     (DEPTH),
    .W         (RW),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (qual),
    .wdata (rec_in),
    .pop   (out_ready),
    .rdata (rec_out),
    .level (level),
    .full  (full),
    .empty (empty),
    .drop  (fifo_drop)
  );

endmodule

// File: tb/tb_reg_write_tracer.sv
// Bench for reg_write_tracer: three configurations share one stimulus.
// A queue-based model predicts every output after every clock edge.
module tb_reg_write_tracer;

  logic        clk = 0;
  logic        reset;
  logic        capture_en;
  logic        clear;
  logic [31:0] pc;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        out_ready;

  logic        v0, f0, e0;
  logic [15:0] cy0;
  logic [31:0] pc0, d0;
  logic [4:0]  rg0, lv0;
  logic [7:0]  dr0;

  logic        v1, f1, e1;
  logic [3:0]  cy1;
  logic [31:0] pc1, d1;
  logic [4:0]  rg1;
  logic [2:0]  lv1;
  logic [7:0]  dr1;

  logic        v2, f2, e2;
  logic [3:0]  cy2;
  logic [31:0] pc2, d2;
  logic [4:0]  rg2;
  logic [2:0]  lv2;
  logic [7:0]  dr2;

  always #5 clk = ~clk;

  reg_write_tracer u0 (
    .clk(clk), .reset(reset), .capture_en(capture_en),
    .clear(clear), .pc(pc), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data),
    .out_valid(v0), .out_ready(out_ready), .out_cycle(cy0),
    .out_pc(pc0), .out_reg(rg0), .out_data(d0),
    .level(lv0), .full(f0), .empty(e0), .dropped(dr0)
  );

  reg_write_tracer #(
    .DEPTH(4), .CNT_W(4), .OVERWRITE(1'b0)
  ) u1 (
    .clk(clk), .reset(reset), .capture_en(capture_en),
    .clear(clear), .pc(pc), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data),
    .out_valid(v1), .out_ready(out_ready), .out_cycle(cy1),
    .out_pc(pc1), .out_reg(rg1), .out_data(d1),
    .level(lv1), .full(f1), .empty(e1), .dropped(dr1)
  );

  reg_write_tracer #(
    .DEPTH(4), .CNT_W(4), .OVERWRITE(1'b1)
  ) u2 (
    .clk(clk), .reset(reset), .capture_en(capture_en),
    .clear(clear), .pc(pc), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data),
    .out_valid(v2), .out_ready(out_ready), .out_cycle(cy2),
    .out_pc(pc2), .out_reg(rg2), .out_data(d2),
    .level(lv2), .full(f2), .empty(e2), .dropped(dr2)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] pc;
    logic [4:0]  r;
    logic [31:0] d;
  } rec_t;

  rec_t        mq [3][$];
  int          mdrop [3];
  int unsigned mcyc;
  int          cfg_depth [3] = '{16, 4, 4};
  bit          cfg_ow [3]    = '{1'b0, 1'b0, 1'b1};
  int          cfg_cw [3]    = '{16, 4, 4};
  logic [31:0] watch = 32'h03FF_FF00;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic get_out(
    input  int i,
    output logic v, output logic e, output logic f,
    output logic [63:0] cy, output logic [63:0] lv,
    output logic [63:0] dr, output logic [63:0] p,
    output logic [63:0] rg, output logic [63:0] d
  );
    case (i)
      0: begin
        v = v0; e = e0; f = f0; cy = 64'(cy0); lv = 64'(lv0);
        dr = 64'(dr0); p = 64'(pc0); rg = 64'(rg0); d = 64'(d0);
      end
      1: begin
        v = v1; e = e1; f = f1; cy = 64'(cy1); lv = 64'(lv1);
        dr = 64'(dr1); p = 64'(pc1); rg = 64'(rg1); d = 64'(d1);
      end
      default: begin
        v = v2; e = e2; f = f2; cy = 64'(cy2); lv = 64'(lv2);
        dr = 64'(dr2); p = 64'(pc2); rg = 64'(rg2); d = 64'(d2);
      end
    endcase
  endtask

  task automatic compare_all();
    logic v, e, f;
    logic [63:0] cy, lv, dr, p, rg, d;
    int sz;
    for (int i = 0; i < 3; i++) begin
      get_out(i, v, e, f, cy, lv, dr, p, rg, d);
      sz = mq[i].size();
      chk($sformatf("u%0d.valid", i), 64'(v), 64'(sz > 0));
      chk($sformatf("u%0d.empty", i), 64'(e), 64'(sz == 0));
      chk($sformatf("u%0d.full", i), 64'(f),
          64'(sz == cfg_depth[i]));
      chk($sformatf("u%0d.level", i), lv, 64'(sz));
      chk($sformatf("u%0d.dropped", i), dr, 64'(mdrop[i]));
      if (sz > 0) begin
        chk($sformatf("u%0d.cycle", i), cy, 64'(mq[i][0].cyc));
        chk($sformatf("u%0d.pc", i), p, 64'(mq[i][0].pc));
        chk($sformatf("u%0d.reg", i), rg, 64'(mq[i][0].r));
        chk($sformatf("u%0d.data", i), d, 64'(mq[i][0].d));
      end
    end
  endtask

  // Reference behaviour for the coming edge, from the current inputs.
  task automatic model_edge();
    bit   qual, pop, isfull;
    rec_t r;
    qual = capture_en && reg_write && (write_reg != 0)
        && watch[write_reg];
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        mq[i].delete();
        mdrop[i] = 0;
      end else begin
        pop    = out_ready && (mq[i].size() > 0);
        isfull = (mq[i].size() == cfg_depth[i]);
        r.cyc  = mcyc % (32'd1 << cfg_cw[i]);
        r.pc   = pc;
        r.r    = write_reg;
        r.d    = write_data;
        if (pop) void'(mq[i].pop_front());
        if (qual) begin
          if (!isfull || pop) begin
            mq[i].push_back(r);
          end else begin
            if (cfg_ow[i]) begin
              void'(mq[i].pop_front());
              mq[i].push_back(r);
            end
            if (mdrop[i] < 255) mdrop[i]++;
          end
        end
      end
    end
    mcyc++;
  endtask

  task automatic step();
    if (!reset) model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mdrop[i] = 0;
    end
    mcyc = 0;
  endtask

  task automatic do_reset();
    logic v, e, f;
    logic [63:0] cy, lv, dr, p, rg, d;
    reset = 1;
    #1;
    model_reset();
    compare_all();
    for (int i = 0; i < 3; i++) begin
      get_out(i, v, e, f, cy, lv, dr, p, rg, d);
      chk($sformatf("rst.u%0d.cycle", i), cy, 0);
      chk($sformatf("rst.u%0d.pc", i), p, 0);
      chk($sformatf("rst.u%0d.reg", i), rg, 0);
      chk($sformatf("rst.u%0d.data", i), d, 0);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic idle();
    capture_en = 1;
    clear      = 0;
    reg_write  = 0;
    write_reg  = 0;
    write_data = 0;
    out_ready  = 0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    reg_write  = 1;
    write_reg  = r;
    write_data = d;
    pc         = $urandom;
    step();
    reg_write  = 0;
  endtask

  initial begin
    pc = 0;
    idle();
    do_reset();

    // $s0 <- 0x12 in cycle 3, visible from cycle 4
    repeat (3) step();
    chk("t1.valid_before", 64'(v0), 0);
    wr(5'd16, 32'h12);
    chk("t1.cycle", 64'(cy0), 3);
    chk("t1.reg", 64'(rg0), 16);
    chk("t1.data", 64'(d0), 32'h12);
    chk("t1.level", 64'(lv0), 1);

    // unqualified writes
    capture_en = 0;
    wr(5'd0, 32'h1);
    wr(5'd2, 32'h2);
    wr(5'd17, 32'h3);
    capture_en = 1;
    wr(5'd0, 32'h4);
    wr(5'd2, 32'h5);
    wr(5'd31, 32'h6);
    chk("t2.level", 64'(lv0), 1);

    // six writes into a stalled FIFO
    clear = 1;
    step();
    clear = 0;
    for (int k = 1; k <= 6; k++) wr(5'(7 + k), 32'(k));
    chk("t3.u1.full", 64'(f1), 1);
    chk("t3.u1.level", 64'(lv1), 4);
    chk("t3.u1.dropped", 64'(dr1), 2);
    chk("t3.u2.full", 64'(f2), 1);
    chk("t3.u2.dropped", 64'(dr2), 2);
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t3.u1.order", 64'(d1), 64'(k + 1));
      chk("t3.u2.order", 64'(d2), 64'(k + 3));
      step();
    end
    out_ready = 0;

    // full with push+pop, then clear with push
    clear = 1;
    step();
    clear = 0;
    for (int k = 0; k < 5; k++) wr(5'd20, 32'(100 + k));
    chk("t4.u1.dropped_pre", 64'(dr1), 1);
    out_ready = 1;
    wr(5'd21, 32'hABCD);
    out_ready = 0;
    chk("t4.u1.level", 64'(lv1), 4);
    chk("t4.u1.dropped", 64'(dr1), 1);
    clear = 1;
    wr(5'd22, 32'hBEEF);
    clear = 0;
    chk("t4.u1.level_clr", 64'(lv1), 0);
    chk("t4.u1.dropped_clr", 64'(dr1), 0);
    chk("t4.u0.level_clr", 64'(lv0), 0);

    // counter wrap and reset mid-drain
    do_reset();
    repeat (17) step();
    wr(5'd9, 32'hAB);
    chk("t5.u1.cycle_wrap", 64'(cy1), 1);
    chk("t5.u0.cycle", 64'(cy0), 17);
    wr(5'd10, 32'h1);
    wr(5'd11, 32'h2);
    out_ready = 1;
    step();
    reset = 1;
    #1;
    chk("t5.u0.valid_rst", 64'(v0), 0);
    chk("t5.u1.valid_rst", 64'(v1), 0);
    chk("t5.u2.valid_rst", 64'(v2), 0);
    out_ready = 0;
    do_reset();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) begin
        idle();
        do_reset();
      end
      capture_en = ($urandom_range(9) != 0);
      clear      = ($urandom_range(49) == 0);
      reg_write  = $urandom_range(1);
      write_reg  = 5'($urandom);
      write_data = $urandom;
      pc         = $urandom;
      out_ready  = ($urandom_range(9) < 4);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_write_tracer.md
# reg_write_tracer

Parametrised, synthesizable register-write trace buffer for the single-cycle and upcoming pipelined MIPS cores. It snoops the register-file write port and timestamps each qualifying write with a free-running cycle count and the committing PC. Records are queued in an internal FIFO and drained over a valid/ready stream. It replaces per-cycle `$display` register dumps with a hardware trace that also works on FPGA.

## Interface
- `DATA_W`, 32: width of PC and write data.
- `REG_AW`, 5: register index width (2^REG_AW registers).
- `DEPTH`, 16: FIFO entries, power of two, ≥ 2.
- `CNT_W`, 16: timestamp width.
- `WATCH_MASK`, 32'h03FF_FF00: bit i set means writes to register i are traced (default $t0–$t9, $s0–$s7).
- `OVERWRITE`, 0: 0 = drop new records when full; 1 = overwrite oldest.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `capture_en` in 1: tracing enabled.
- `clear` in 1: synchronous flush of FIFO and drop counter.
- `pc` in DATA_W: PC of the committing instruction.
- `reg_write` in 1: register-file write enable.
- `write_reg` in REG_AW: destination register.
- `write_data` in DATA_W: value written.
- `out_valid` out 1: head record available.
- `out_ready` in 1: consumer accepts the head record.
- `out_cycle` out CNT_W: head timestamp.
- `out_pc` out DATA_W: head PC.
- `out_reg` out REG_AW: head register index.
- `out_data` out DATA_W: head write data.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `full` out 1, `empty` out 1: occupancy flags.
- `dropped` out 8: count of lost records, saturates at 255.

## Operation
- Qualifying write: `capture_en & reg_write & (write_reg != 0) & WATCH_MASK[write_reg]`. Writes to register 0 are never traced.
- A push stores {cycle, pc, write_reg, write_data}. `cycle` is the counter value in the push cycle.
- Cycle counter: increments every clock from 0 after reset. Wraps modulo 2^CNT_W. Unaffected by `clear` and `capture_en`.
- Pop happens when `out_valid & out_ready`. The head advances.
- Push and pop in the same cycle: both occur and `level` is unchanged. When full, the pop frees a slot, so the push is accepted and nothing is dropped.
- Full with push and no pop:
  - OVERWRITE=0: the record is discarded and `dropped` increments.
  - OVERWRITE=1: the oldest entry is discarded (read pointer advances), the new record is written, `level` stays DEPTH, and `dropped` increments.
- `clear` has priority over push and pop in the same cycle. It empties the FIFO and zeroes `dropped`. The push in that cycle is lost and is not counted.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `full = (level == DEPTH)`, `empty = (level == 0)`, `out_valid = ~empty`.

## Timing
- Reset values: all pointers, `level`, `dropped` and the cycle counter are 0. `out_valid`=0, `empty`=1, `full`=0. `out_*` fields are 0 (the memory head reads 0 after reset).
- Latency: a push on edge N gives `out_valid`=1 after edge N, so the record is visible in cycle N+1.
- Out fields are driven from the head entry and must hold stable while `out_valid & ~out_ready`.
- In OVERWRITE mode the head may change without a pop, but only on a full-push edge.
- Asserting `reset` mid-stream immediately forces the reset values. Record contents need not be cleared.

## Structure
- The shared package `trace_pkg` holds:
  - the record field-width constants;
  - the default watch mask `TRACE_MASK_ST` (32'h03FF_FF00);
  - the mode constants `TRACE_DROP`=0 and `TRACE_OVERWRITE`=1.
- Sub-module `trace_fifo`: a generic DEPTH×W storage with push/pop/overwrite and level logic.
- The top level holds qualification, the cycle counter, the `dropped` counter and record packing.

## Test plan
- Reset, then write $s0←0x12 at cycle 3 with the default mask -> one record {3, pc, 16, 0x12}; `out_valid` first seen in cycle 4; `level`=1.
- Writes to $zero, $v0 (reg 2) and $s1 with `capture_en`=0 -> no push; `level` stays 0.
- DEPTH=4, OVERWRITE=0, `out_ready`=0, six qualifying writes -> `full`=1, `level`=4, `dropped`=2; drained records are the first four, in order.
- DEPTH=4, OVERWRITE=1, six writes with data 1..6 -> drained data is 3,4,5,6; `dropped`=2.
- Full FIFO with a simultaneous push and pop -> `level` stays 4 and `dropped` is unchanged; `clear` with a push in the same cycle -> `level`=0, `dropped`=0.
- CNT_W=4, a write at cycle 17 -> `out_cycle`=1 (wrapped); asserting `reset` mid-drain -> `out_valid`=0 at once.
